// File: rtl/adc_ad4003_ctrl.sv
// AD4003 conversion/readout sequencer: periodic CNV pulse, 40 MHz SCK read burst, optional 16-bit config write.
// Latency: each frame starts on the cycle after period count 0; outputs are registered, no input-to-output comb path.
// No backpressure; config writes are enabled by the ADC_CFG_WRITE_EN macro (default build: no config path).
module adc_ad4003_ctrl #(
  parameter int ADC_DATA_WIDTH  = 18,
  parameter int PERIOD_CYCLES   = 80,
  parameter int CNV_HIGH_CYCLES = 4,
  parameter int CONV_CYCLES     = 24
) (
  input  logic       adc_spi_clk,
  input  logic       rstn,
  input  logic       run_en,
  input  logic       cfg_wr_req,
  input  logic [7:0] cfg_wr_data,
  output logic       cnvst,
  output logic       sck,
  output logic       sdi,
  output logic       reader_en_sync,
  output logic       sample_valid,
  output logic       cfg_done,
  output logic       busy
);

  localparam int MAX_BITS   = (ADC_DATA_WIDTH > 16) ? ADC_DATA_WIDTH : 16;
  localparam int MIN_PERIOD = CNV_HIGH_CYCLES + CONV_CYCLES + 2 * MAX_BITS + 2;
  localparam int CW         = $clog2(PERIOD_CYCLES);

  localparam logic [CW-1:0] CNT_LAST  = CW'(PERIOD_CYCLES - 1);
  localparam logic [CW-1:0] CNV_LAST  = CW'(CNV_HIGH_CYCLES - 1);
  localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYCLES - 1);
  localparam logic [CW-1:0] READ_LAST = CW'(2 * ADC_DATA_WIDTH - 1);

  // The frame sequence must fit inside one conversion period.
  generate
    if (PERIOD_CYCLES < MIN_PERIOD) begin : g_period_check
      $error("adc_ad4003_ctrl: PERIOD_CYCLES too small for the frame sequence");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE, CNV_HI, CONV_WAIT, READ, CFG_WR, GAP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] sub;

`ifdef ADC_CFG_WRITE_EN
  localparam logic [7:0]    CFG_CMD  = 8'h14;
  localparam logic [CW-1:0] CFG_LAST = CW'(31);
  logic        cfg_pending;
  logic [7:0]  cfg_data;
  logic [15:0] shreg;
`else
  // Config inputs have no function in this build.
  logic unused_cfg;
  assign unused_cfg = cfg_wr_req ^ (^cfg_wr_data);
  assign sdi        = 1'b1;
  assign cfg_done   = 1'b0;
`endif

  // Free-running period counter; frames may only start when it reads 0.
  always_ff @(posedge adc_spi_clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

  // Frame sequencer with registered pin outputs.
  always_ff @(posedge adc_spi_clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      sub            <= '0;
      cnvst          <= 1'b0;
      sck            <= 1'b0;
      reader_en_sync <= 1'b0;
      sample_valid   <= 1'b0;
      busy           <= 1'b0;
`ifdef ADC_CFG_WRITE_EN
      sdi            <= 1'b1;
      cfg_done       <= 1'b0;
      cfg_pending    <= 1'b0;
      cfg_data       <= '0;
      shreg          <= '0;
`endif
    end else begin
      sample_valid <= 1'b0;
`ifdef ADC_CFG_WRITE_EN
      cfg_done <= 1'b0;
      // A request is only taken while nothing is pending; later ones are dropped.
      if (cfg_wr_req && !cfg_pending) begin
        cfg_pending <= 1'b1;
        cfg_data    <= cfg_wr_data;
      end
`endif
      case (state)
        IDLE, GAP: begin
          if (cnt == '0) begin
`ifdef ADC_CFG_WRITE_EN
            if (cfg_pending) begin
              state <= CFG_WR;
              busy  <= 1'b1;
              sck   <= 1'b0;
              sdi   <= CFG_CMD[7];
              shreg <= {CFG_CMD[6:0], cfg_data, 1'b0};
              sub   <= '0;
            end else
`endif
            if (run_en) begin
              state <= CNV_HI;
              busy  <= 1'b1;
              cnvst <= 1'b1;
              sub   <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        CNV_HI: begin
          if (sub == CNV_LAST) begin
            state <= CONV_WAIT;
            cnvst <= 1'b0;
            sub   <= '0;
          end else begin
            sub <= sub + 1'b1;
          end
        end
        CONV_WAIT: begin
          if (sub == CONV_LAST) begin
            state          <= READ;
            sck            <= 1'b1;
            reader_en_sync <= 1'b1;
            sub            <= '0;
          end else begin
            sub <= sub + 1'b1;
          end
        end
        READ: begin
          if (sub == READ_LAST) begin
            state          <= GAP;
            sck            <= 1'b0;
            reader_en_sync <= 1'b0;
            sample_valid   <= 1'b1;
          end else begin
            sck <= ~sck;
            sub <= sub + 1'b1;
          end
        end
`ifdef ADC_CFG_WRITE_EN
        CFG_WR: begin
          if (sub == CFG_LAST) begin
            state       <= GAP;
            sck         <= 1'b0;
            sdi         <= 1'b1;
            cfg_done    <= 1'b1;
            cfg_pending <= 1'b0;
          end else begin
            sck <= ~sck;
            sub <= sub + 1'b1;
            // Next bit goes out together with the sck falling edge.
            if (sck) begin
              sdi   <= shreg[15];
              shreg <= {shreg[14:0], 1'b0};
            end
          end
        end
`endif
        default: begin
          state          <= IDLE;
          busy           <= 1'b0;
          cnvst          <= 1'b0;
          sck            <= 1'b0;
          reader_en_sync <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_ad4003_ctrl.sv
// Directed bench for adc_ad4003_ctrl with default parameters; config-write cases run when ADC_CFG_WRITE_EN is defined.
// Outputs are observed on the falling clock edge and timestamped with the rising-edge cycle count.
// Expected timings are hand-derived from the frame sequence (CNV 4, wait 24, read 36, period 80).
module tb_adc_ad4003_ctrl;

  logic       adc_spi_clk = 1'b0;
  logic       rstn        = 1'b0;
  logic       run_en      = 1'b0;
  logic       cfg_wr_req  = 1'b0;
  logic [7:0] cfg_wr_data = 8'h00;
  logic       cnvst, sck, sdi, reader_en_sync, sample_valid, cfg_done, busy;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc     = 0;
  int rel     = 0;

  int cnv_rise[$];
  int cnv_fall[$];
  int sck_rise[$];
  int sv_at[$];
  int cd_at[$];
  int ren_cycles = 0;
  int sdi_low    = 0;
  logic [15:0] sdi_sr   = '0;
  logic [15:0] cfg_word = '0;
  logic p_cnvst = 1'b0;
  logic p_sck   = 1'b0;

  adc_ad4003_ctrl dut (
    .adc_spi_clk    (adc_spi_clk),
    .rstn           (rstn),
    .run_en         (run_en),
    .cfg_wr_req     (cfg_wr_req),
    .cfg_wr_data    (cfg_wr_data),
    .cnvst          (cnvst),
    .sck            (sck),
    .sdi            (sdi),
    .reader_en_sync (reader_en_sync),
    .sample_valid   (sample_valid),
    .cfg_done       (cfg_done),
    .busy           (busy)
  );

  always #5 adc_spi_clk = ~adc_spi_clk;

  always @(posedge adc_spi_clk) cyc <= cyc + 1;

  // Event monitor on the falling edge.
  always @(negedge adc_spi_clk) begin
    if (cnvst && !p_cnvst) cnv_rise.push_back(cyc);
    if (!cnvst && p_cnvst) cnv_fall.push_back(cyc);
    if (sck && !p_sck) begin
      sck_rise.push_back(cyc);
      sdi_sr = {sdi_sr[14:0], sdi};
    end
    if (sample_valid) sv_at.push_back(cyc);
    if (cfg_done) begin
      cd_at.push_back(cyc);
      cfg_word = sdi_sr;
    end
    if (reader_en_sync) ren_cycles++;
    if (!sdi) sdi_low++;
    p_cnvst = cnvst;
    p_sck   = sck;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1000;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge adc_spi_clk);
      #1;
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick(1);
  endtask

  task automatic clear_mon();
    cnv_rise.delete();
    cnv_fall.delete();
    sck_rise.delete();
    sv_at.delete();
    cd_at.delete();
    ren_cycles = 0;
    sdi_low    = 0;
    sdi_sr     = '0;
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "_cnvst"}, 32'(cnvst), 0);
    chk({pfx, "_sck"}, 32'(sck), 0);
    chk({pfx, "_sdi"}, 32'(sdi), 1);
    chk({pfx, "_reader_en"}, 32'(reader_en_sync), 0);
    chk({pfx, "_sample_valid"}, 32'(sample_valid), 0);
    chk({pfx, "_cfg_done"}, 32'(cfg_done), 0);
    chk({pfx, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(2);
    check_reset("rst");

    // Periodic conversions, three full periods
    clear_mon();
    run_en = 1'b1;
    rstn   = 1'b1;
    rel    = cyc;
    tick(3);
    chk("busy_in_frame", 32'(busy), 1);
`ifndef ADC_CFG_WRITE_EN
    cfg_wr_req  = 1'b1;
    cfg_wr_data = 8'h35;
    tick(1);
    cfg_wr_req  = 1'b0;
`endif
    wait_until(rel + 240);
    chk("cnv_count", cnv_rise.size(), 3);
    chk("cnv_first_at", qat(cnv_rise, 0) - rel, 1);
    chk("cnv_period_1", qat(cnv_rise, 1) - qat(cnv_rise, 0), 80);
    chk("cnv_period_2", qat(cnv_rise, 2) - qat(cnv_rise, 1), 80);
    chk("cnv_width", qat(cnv_fall, 0) - qat(cnv_rise, 0), 4);
    chk("sck_count", sck_rise.size(), 54);
    chk("sck_first_delay", qat(sck_rise, 0) - qat(cnv_rise, 0), 28);
    chk("sck_burst_span", qat(sck_rise, 17) - qat(sck_rise, 0), 34);
    chk("sv_count", sv_at.size(), 3);
    chk("sv_delay", qat(sv_at, 0) - qat(cnv_rise, 0), 64);
    chk("reader_en_cycles", ren_cycles, 108);
    chk("sdi_low_cycles", sdi_low, 0);
    chk("cfg_done_count", cd_at.size(), 0);

    // run_en dropped during READ of the fourth frame
    wait_until(rel + 275);
    run_en = 1'b0;
    wait_until(rel + 480);
    chk("stop_cnv_count", cnv_rise.size(), 4);
    chk("stop_sck_count", sck_rise.size(), 72);
    chk("stop_sv_count", sv_at.size(), 4);
    chk("stop_busy", 32'(busy), 0);

    // Reset in READ after 7 sck edges
    clear_mon();
    run_en = 1'b1;
    for (int i = 0; i < 200 && sck_rise.size() < 7; i++) tick(1);
    chk("abort_reached_7", sck_rise.size(), 7);
    rstn = 1'b0;
    #1;
    check_reset("abort");
    tick(3);
    chk("abort_no_sv", sv_at.size(), 0);
    clear_mon();
    rstn = 1'b1;
    rel  = cyc;
    wait_until(rel + 70);
    chk("restart_cnv_at", qat(cnv_rise, 0) - rel, 1);
    chk("restart_sck_count", sck_rise.size(), 18);
    chk("restart_sv_count", sv_at.size(), 1);

`ifdef ADC_CFG_WRITE_EN
    // Config write with a second request while the first is pending
    rstn = 1'b0;
    run_en = 1'b0;
    tick(2);
    clear_mon();
    rstn = 1'b1;
    rel  = cyc;
    tick(5);
    cfg_wr_req  = 1'b1;
    cfg_wr_data = 8'h35;
    tick(1);
    cfg_wr_req  = 1'b0;
    tick(10);
    cfg_wr_req  = 1'b1;
    cfg_wr_data = 8'hAA;
    tick(1);
    cfg_wr_req  = 1'b0;
    run_en      = 1'b1;
    wait_until(rel + 240);
    chk("cfg_done_count", cd_at.size(), 1);
    chk("cfg_done_at", qat(cd_at, 0) - rel, 113);
    chk("cfg_word", 32'(cfg_word), 32'h1435);
    chk("cfg_first_sck_at", qat(sck_rise, 0) - rel, 82);
    chk("cfg_sck_total", sck_rise.size(), 34);
    chk("cfg_cnv_count", cnv_rise.size(), 1);
    chk("cfg_cnv_resume_at", qat(cnv_rise, 0) - rel, 161);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
